ibex_dii_instr_feeder: RTL

// - Instruction-side responder for ibex_top_sram in the TestRIG (RVFI-DII) bench. It replaces instruction memory.
// - Buffers injected instructions from the DII stream and answers Ibex fetches in injection order, not by address.
// - Rewinds to the oldest unretired instruction when the core flushes its prefetch path.
// - Frees buffer slots as rvfi_valid retirements arrive.

---
 rtl/ibex_dii_pkg.sv | 25 ++
 rtl/ibex_dii_resp_stage.sv | 66 ++++++
 rtl/ibex_dii_instr_feeder.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ibex_dii_pkg.sv
// Shared constants, types and the instruction-bus integrity encoder for the DII feeder.
package ibex_dii_pkg;

  localparam logic [31:0] DII_NOP             = 32'h00000013;
  localparam int unsigned DII_MAX_OUTSTANDING = 2;
  localparam int unsigned DII_DEPTH           = 16;
  localparam int unsigned DII_PW              = $clog2(DII_DEPTH) + 1;
  localparam logic [6:0]  DII_INTG_INV        = 7'h2A;

  typedef logic [DII_PW-1:0] dii_ptr_t;

  // Inverted SECDED(39,32) check bits, bit-compatible with prim_secded_inv_39_32_enc.
  function automatic logic [6:0] dii_secded_inv_39_32_enc(input logic [31:0] data);
    logic [6:0] ecc;
    ecc[0] = ^(data & 32'h2606BD25);
    ecc[1] = ^(data & 32'hDEBA8050);
    ecc[2] = ^(data & 32'h413D89AA);
    ecc[3] = ^(data & 32'h31234ED1);
    ecc[4] = ^(data & 32'hC2C1323B);
    ecc[5] = ^(data & 32'h2DCC624C);
    ecc[6] = ^(data & 32'h98505586);
    return ecc ^ DII_INTG_INV;
  endfunction

endpackage

// File: rtl/ibex_dii_resp_stage.sv
// Single register stage for fetch responses: rvalid/rdata/err, outstanding
// request counter and the integrity bits of the returned word.
module ibex_dii_resp_stage
  import ibex_dii_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        gnt_i,
  input  logic [31:0] rdata_i,
  input  logic        err_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [6:0]  rdata_intg_o,
  output logic [1:0]  outstanding_o
);

  localparam logic [1:0] MaxOut = 2'(DII_MAX_OUTSTANDING);

  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [1:0]  r_outstanding;

  // Capture the granted response; the counter tracks grants not yet answered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid      <= 1'b0;
      r_rdata       <= 32'h00000000;
      r_err         <= 1'b0;
      r_outstanding <= 2'd0;
    end else begin
      r_rvalid <= gnt_i;
      r_err    <= gnt_i & err_i;
      if (gnt_i) begin
        r_rdata <= rdata_i;
      end else begin
        r_rdata <= r_rdata;
      end
      case ({gnt_i, r_rvalid})
        2'b10: begin
          if (r_outstanding < MaxOut) begin
            r_outstanding <= r_outstanding + 2'd1;
          end else begin
            r_outstanding <= r_outstanding;
          end
        end
        2'b01: begin
          if (r_outstanding != 2'd0) begin
            r_outstanding <= r_outstanding - 2'd1;
          end else begin
            r_outstanding <= r_outstanding;
          end
        end
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign rvalid_o      = r_rvalid;
  assign rdata_o       = r_rdata;
  assign err_o         = r_err;
  assign outstanding_o = r_outstanding;
  assign rdata_intg_o  = dii_secded_inv_39_32_enc(r_rdata);

endmodule

// File: rtl/ibex_dii_instr_feeder.sv
// DII instruction feeder: buffers injected instructions and serves Ibex fetches in
// injection order, rewinding to the oldest unretired entry on a fetch flush.
module ibex_dii_instr_feeder
  import ibex_dii_pkg::*;
#(
  parameter int unsigned Depth   = DII_DEPTH,
  parameter logic [31:0] NopInsn = DII_NOP
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        dii_valid_i,
  output logic        dii_ready_o,
  input  logic [31:0] dii_insn_i,
  input  logic        drain_i,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic [6:0]  instr_rdata_intg_o,
  output logic        instr_err_o,
  input  logic        fetch_flush_i,
  input  logic        rvfi_valid_i,
  output logic        underflow_o
);

  localparam int unsigned   PW      = $clog2(Depth) + 1;
  localparam logic [PW-1:0] PtrOne  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] PtrFull = PW'(Depth);
  localparam logic [1:0]    MaxOut  = 2'(DII_MAX_OUTSTANDING);

  logic [31:0]   r_mem [Depth];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_fe_ptr;
  logic [PW-1:0] r_cm_ptr;
  logic          r_underflow;

  logic [PW-1:0] w_count;
  logic          w_full;
  logic          w_avail;
  logic          w_push;
  logic          w_gnt;
  logic          w_retire;
  logic          w_underflow_evt;
  logic [PW-1:0] w_cm_next;
  logic [31:0]   w_fetch_data;
  logic          w_fetch_err;
  logic [1:0]    w_outstanding;
  logic          w_unused_addr;

  // Extra pointer bit distinguishes full from empty when the indices coincide.
  assign w_count         = r_wr_ptr - r_cm_ptr;
  assign w_full          = (w_count == PtrFull);
  assign w_avail         = (r_fe_ptr != r_wr_ptr);
  assign w_push          = dii_valid_i & ~w_full;
  assign dii_ready_o     = ~w_full;

  assign w_gnt           = rst_ni & instr_req_i & ~fetch_flush_i & (w_avail | drain_i) &
                           (w_outstanding < MaxOut);
  assign instr_gnt_o     = w_gnt;

  // A retire with nothing handed out is a trace/core disagreement, not a free slot.
  assign w_retire        = rvfi_valid_i & (r_cm_ptr != r_fe_ptr);
  assign w_underflow_evt = rvfi_valid_i & (r_cm_ptr == r_fe_ptr);
  assign w_cm_next       = w_retire ? (r_cm_ptr + PtrOne) : r_cm_ptr;

  assign w_fetch_data    = w_avail ? r_mem[r_fe_ptr[PW-2:0]] : NopInsn;
  assign w_fetch_err     = (instr_addr_i[1:0] != 2'b00);
  assign w_unused_addr   = ^instr_addr_i[31:2];
  assign underflow_o     = r_underflow;

  // Instruction storage; contents need no reset since pointers gate every read.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr[PW-2:0]] <= dii_insn_i;
    end else begin
      r_mem[r_wr_ptr[PW-2:0]] <= r_mem[r_wr_ptr[PW-2:0]];
    end
  end

  // Write, fetch and commit pointers plus the sticky underflow flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr    <= '0;
      r_fe_ptr    <= '0;
      r_cm_ptr    <= '0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrOne;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      r_cm_ptr <= w_cm_next;
      if (fetch_flush_i) begin
        r_fe_ptr <= w_cm_next;
      end else if (w_gnt & w_avail) begin
        r_fe_ptr <= r_fe_ptr + PtrOne;
      end else begin
        r_fe_ptr <= r_fe_ptr;
      end
      if (w_underflow_evt) begin
        r_underflow <= 1'b1;
      end else begin
        r_underflow <= r_underflow;
      end
    end
  end

  ibex_dii_resp_stage u_resp_stage (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .gnt_i         (w_gnt),
    .rdata_i       (w_fetch_data),
    .err_i         (w_fetch_err),
    .rvalid_o      (instr_rvalid_o),
    .rdata_o       (instr_rdata_o),
    .err_o         (instr_err_o),
    .rdata_intg_o  (instr_rdata_intg_o),
    .outstanding_o (w_outstanding)
  );

endmodule
